// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the pipelined MIPS core front end.
//   - Default vector addresses (reset, interrupt entry, exception entry).
//   - The instruction word used for pipeline bubbles.
//   - redirect_e: the redirect chosen by the fetch-stage arbiter each cycle.
//   - Helper functions that classify a redirect.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W = 32;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  // Next-PC source chosen by the arbiter for the current cycle.
  typedef enum logic [2:0] {
    RD_SEQ    = 3'd0,
    RD_JUMP   = 3'd1,
    RD_BRANCH = 3'd2,
    RD_EXC    = 3'd3,
    RD_IRQ    = 3'd4,
    RD_HOLD   = 3'd5
  } redirect_e;

  // Redirects that kill the instruction currently in ID (it must not reach EX).
  function automatic logic redirect_squashes_id(input redirect_e rd);
    return (rd == RD_BRANCH) || (rd == RD_EXC);
  endfunction

  // Redirects that enter a handler and therefore write epc.
  function automatic logic redirect_is_trap(input redirect_e rd);
    return (rd == RD_EXC) || (rd == RD_IRQ);
  endfunction

endpackage

// File: rtl/pc_redirect_arbiter.sv
// pc_redirect_arbiter
//   Purely combinational next-PC selection for the fetch stage.
//   Priority, highest first: EX branch, ID exception, interrupt (user mode,
//   unstalled), ID jump (unstalled), stall hold, sequential fetch.
//   Reset is handled by the owner of the PC register, not here.
//
// Ports
//   pc_i               current PC (bit MSB = kernel mode)
//   pc_plus4_i         sequential successor of pc_i
//   stall_i            load-use hold from the hazard unit
//   id_jump_valid_i    jump resolved in ID
//   id_jump_target_i   jump target (full address, kernel bit included)
//   ex_branch_valid_i  taken branch resolved in EX
//   ex_branch_target_i branch target
//   exc_req_i          undefined opcode in ID
//   irq_i              level interrupt request
//   redirect_o         selected redirect source
//   next_pc_o          PC value for the next cycle
module pc_redirect_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]     ILLOP_VEC = ADDR_W'(DEF_ILLOP_VEC),
  parameter logic [ADDR_W-1:0]     XADR_VEC  = ADDR_W'(DEF_XADR_VEC)
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] pc_plus4_i,
  input  logic              stall_i,
  input  logic              id_jump_valid_i,
  input  logic [ADDR_W-1:0] id_jump_target_i,
  input  logic              ex_branch_valid_i,
  input  logic [ADDR_W-1:0] ex_branch_target_i,
  input  logic              exc_req_i,
  input  logic              irq_i,
  output redirect_e         redirect_o,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic kernel;
  logic irq_take;

  // Kernel mode lives in the PC MSB and masks the interrupt. An interrupt
  // that is masked or stalled is simply not taken this cycle; because irq is
  // a level it is reconsidered on every following cycle.
  assign kernel   = pc_i[ADDR_W-1];
  assign irq_take = irq_i && !kernel && !stall_i;

  always_comb begin
    redirect_o = RD_SEQ;
    next_pc_o  = pc_plus4_i;
    if (ex_branch_valid_i) begin
      // The branch belongs to an older instruction, so it beats everything
      // younger, including a trap raised by the instruction behind it.
      redirect_o = RD_BRANCH;
      next_pc_o  = ex_branch_target_i;
    end else if (exc_req_i) begin
      redirect_o = RD_EXC;
      next_pc_o  = XADR_VEC;
    end else if (irq_take) begin
      redirect_o = RD_IRQ;
      next_pc_o  = ILLOP_VEC;
    end else if (id_jump_valid_i && !stall_i) begin
      redirect_o = RD_JUMP;
      next_pc_o  = id_jump_target_i;
    end else if (stall_i) begin
      redirect_o = RD_HOLD;
      next_pc_o  = pc_i;
    end
  end

endmodule

// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit
//   Instruction-fetch stage of the pipelined MIPS core. Holds the PC, the
//   IF/ID pipeline register and the epc register; next-PC selection is done
//   by pc_redirect_arbiter.
//
// Flow control: there is no valid/ready handshake towards decode. IF/ID is
// loaded every cycle unless stall is high, in which case PC and IF/ID hold
// their contents. A redirect replaces the fetched word with a bubble
// (valid=0, instr=NOP_INSTR, pc_plus4=0). Branch and exception additionally
// raise squash_id so decode drops the instruction it currently holds.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   imem_addr           PC with the kernel bit cleared, to the ROM
//   imem_rdata          instruction word returned combinationally
//   stall               hold request from the hazard unit
//   id_jump_valid/target      jump resolved in ID
//   ex_branch_valid/target    taken branch resolved in EX
//   exc_req             undefined opcode in ID
//   irq                 level interrupt
//   if_id_valid/instr/pc_plus4  IF/ID register contents
//   squash_id           ID must bubble ID/EX this cycle (combinational)
//   epc, epc_valid      return address for $26 and its one-cycle write strobe
module pipe_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] ILLOP_VEC = ADDR_W'(DEF_ILLOP_VEC),
  parameter logic [ADDR_W-1:0] XADR_VEC  = ADDR_W'(DEF_XADR_VEC),
  parameter logic [31:0]       NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              id_jump_valid,
  input  logic [ADDR_W-1:0] id_jump_target,
  input  logic              ex_branch_valid,
  input  logic [ADDR_W-1:0] ex_branch_target,
  input  logic              exc_req,
  input  logic              irq,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc_plus4,
  output logic              squash_id,
  output logic [ADDR_W-1:0] epc,
  output logic              epc_valid
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4;

  logic              if_id_valid_q, if_id_valid_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic [ADDR_W-1:0] if_id_pc4_q,   if_id_pc4_d;

  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              epc_valid_q, epc_valid_d;

  redirect_e         redirect;
  logic [ADDR_W-1:0] arb_next_pc;

  // The increment only touches the low field so the kernel bit survives;
  // the low field wraps modulo 2^(ADDR_W-1).
  assign pc_plus4  = {pc_q[ADDR_W-1], pc_q[ADDR_W-2:0] + (ADDR_W-1)'(4)};
  assign imem_addr = {1'b0, pc_q[ADDR_W-2:0]};

  pc_redirect_arbiter #(
    .ADDR_W    (ADDR_W),
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_arbiter (
    .pc_i               (pc_q),
    .pc_plus4_i         (pc_plus4),
    .stall_i            (stall),
    .id_jump_valid_i    (id_jump_valid),
    .id_jump_target_i   (id_jump_target),
    .ex_branch_valid_i  (ex_branch_valid),
    .ex_branch_target_i (ex_branch_target),
    .exc_req_i          (exc_req),
    .irq_i              (irq),
    .redirect_o         (redirect),
    .next_pc_o          (arb_next_pc)
  );

  always_comb begin
    pc_d          = arb_next_pc;
    // Default is a bubble: every redirect discards the word being fetched.
    if_id_valid_d = 1'b0;
    if_id_instr_d = NOP_INSTR;
    if_id_pc4_d   = '0;
    epc_d         = epc_q;
    epc_valid_d   = 1'b0;

    unique case (redirect)
      RD_SEQ: begin
        if_id_valid_d = 1'b1;
        if_id_instr_d = imem_rdata;
        if_id_pc4_d   = pc_plus4;
      end
      RD_HOLD: begin
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
      end
      RD_EXC: begin
        // The faulting instruction is the one in ID; return past it.
        epc_d       = if_id_pc4_q;
        epc_valid_d = 1'b1;
      end
      RD_IRQ: begin
        // The ID instruction completes, the one in IF is dropped, so the
        // interrupted point is the instruction currently being fetched.
        epc_d       = pc_plus4;
        epc_valid_d = 1'b1;
      end
      default: begin
        // RD_JUMP and RD_BRANCH only bubble IF/ID.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_VEC;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc4_q   <= '0;
      epc_q         <= '0;
      epc_valid_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      epc_q         <= epc_d;
      epc_valid_q   <= epc_valid_d;
    end
  end

  assign squash_id      = !reset && redirect_squashes_id(redirect);
  assign if_id_valid    = if_id_valid_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc_plus4 = if_id_pc4_q;
  assign epc            = epc_q;
  assign epc_valid      = epc_valid_q;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
module tb_pipe_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        id_jump_valid;
  logic [31:0] id_jump_target;
  logic        ex_branch_valid;
  logic [31:0] ex_branch_target;
  logic        exc_req;
  logic        irq;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        squash_id;
  logic [31:0] epc;
  logic        epc_valid;

  int total = 0;
  int bad   = 0;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word = 0xC000_0000 | address (address MSB is always 0).
  assign imem_rdata = 32'hC000_0000 | imem_addr;

  pipe_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .stall            (stall),
    .id_jump_valid    (id_jump_valid),
    .id_jump_target   (id_jump_target),
    .ex_branch_valid  (ex_branch_valid),
    .ex_branch_target (ex_branch_target),
    .exc_req          (exc_req),
    .irq              (irq),
    .if_id_valid      (if_id_valid),
    .if_id_instr      (if_id_instr),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .squash_id        (squash_id),
    .epc              (epc),
    .epc_valid        (epc_valid)
  );

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_jump(input logic [31:0] tgt);
    id_jump_valid  = 1'b1;
    id_jump_target = tgt;
    step();
    id_jump_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; irq = 1'b0; exc_req = 1'b0;
    id_jump_valid = 1'b0; id_jump_target = '0;
    ex_branch_valid = 1'b0; ex_branch_target = '0;
    repeat (2) step();

    // Reset state
    chk("rst_addr",  imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, 32'h0000_0000);
    chk("rst_pc4",   if_id_pc_plus4, 32'h0);
    chk("rst_epc",   epc, 32'h0);
    chk("rst_epcv",  {31'd0, epc_valid}, 32'd0);
    ex_branch_valid = 1'b1; ex_branch_target = 32'h40; #1;
    chk("rst_squash", {31'd0, squash_id}, 32'd0);
    ex_branch_valid = 1'b0;

    // Free-run from the reset vector
    reset = 1'b0; #1;
    chk("seq0_addr", imem_addr, 32'h0000_0000);
    step();
    chk("seq1_addr",  imem_addr, 32'h0000_0004);
    chk("seq1_pc4",   if_id_pc_plus4, 32'h8000_0004);
    chk("seq1_valid", {31'd0, if_id_valid}, 32'd1);
    chk("seq1_instr", if_id_instr, 32'hC000_0000);
    step();
    chk("seq2_addr",  imem_addr, 32'h0000_0008);
    chk("seq2_pc4",   if_id_pc_plus4, 32'h8000_0008);
    chk("seq2_instr", if_id_instr, 32'hC000_0004);

    // Kernel-mode low-field wrap keeps the kernel bit
    id_jump_valid = 1'b1; id_jump_target = 32'hFFFF_FFFC; #1;
    chk("jmp_nosquash", {31'd0, squash_id}, 32'd0);
    step(); id_jump_valid = 1'b0;
    chk("kwrap_jaddr",  imem_addr, 32'h7FFF_FFFC);
    chk("kwrap_bubble", {31'd0, if_id_valid}, 32'd0);
    chk("kwrap_bpc4",   if_id_pc_plus4, 32'h0);
    step();
    chk("kwrap_addr",  imem_addr, 32'h0000_0000);
    chk("kwrap_pc4",   if_id_pc_plus4, 32'h8000_0000);
    chk("kwrap_instr", if_id_instr, 32'hFFFF_FFFC);

    // User-mode wrap stays in user mode
    do_jump(32'h7FFF_FFFC);
    step();
    chk("uwrap_addr", imem_addr, 32'h0000_0000);
    chk("uwrap_pc4",  if_id_pc_plus4, 32'h0000_0000);
    chk("uwrap_valid", {31'd0, if_id_valid}, 32'd1);

    // Interrupt from user mode at PC=0x100
    do_jump(32'h0000_0100);
    chk("irq_pre_addr", imem_addr, 32'h0000_0100);
    irq = 1'b1; #1;
    chk("irq_nosquash", {31'd0, squash_id}, 32'd0);
    step();
    chk("irq_addr",   imem_addr, 32'h0000_0004);
    chk("irq_epc",    epc, 32'h0000_0104);
    chk("irq_epcv",   {31'd0, epc_valid}, 32'd1);
    chk("irq_bubble", {31'd0, if_id_valid}, 32'd0);
    step();
    chk("irq_mask_epcv",  {31'd0, epc_valid}, 32'd0);
    chk("irq_mask_epc",   epc, 32'h0000_0104);
    chk("irq_mask_addr",  imem_addr, 32'h0000_0008);
    chk("irq_mask_pc4",   if_id_pc_plus4, 32'h8000_0008);
    chk("irq_mask_instr", if_id_instr, 32'hC000_0004);
    step();
    chk("irq_mask2_addr", imem_addr, 32'h0000_000C);
    chk("irq_mask2_epcv", {31'd0, epc_valid}, 32'd0);
    irq = 1'b0;

    // Branch + exception + stall together: branch wins
    ex_branch_valid = 1'b1; ex_branch_target = 32'h40; exc_req = 1'b1; stall = 1'b1; #1;
    chk("br_squash", {31'd0, squash_id}, 32'd1);
    step();
    ex_branch_valid = 1'b0; exc_req = 1'b0; stall = 1'b0;
    chk("br_addr",  imem_addr, 32'h0000_0040);
    chk("br_epcv",  {31'd0, epc_valid}, 32'd0);
    chk("br_epc",   epc, 32'h0000_0104);
    chk("br_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    chk("br_seq_pc4",   if_id_pc_plus4, 32'h0000_0044);
    chk("br_seq_instr", if_id_instr, 32'hC000_0040);

    // Stall with a pending jump: everything frozen, jump taken afterwards
    stall = 1'b1; id_jump_valid = 1'b1; id_jump_target = 32'h0000_0200; #1;
    chk("stall_nosquash", {31'd0, squash_id}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr",  imem_addr, 32'h0000_0044);
      chk("stall_pc4",   if_id_pc_plus4, 32'h0000_0044);
      chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
    end
    stall = 1'b0;
    step(); id_jump_valid = 1'b0;
    chk("stjmp_addr",  imem_addr, 32'h0000_0200);
    chk("stjmp_valid", {31'd0, if_id_valid}, 32'd0);

    // Exception with if_id_pc_plus4 = 0x24
    do_jump(32'h0000_0020);
    step();
    chk("exc_pre_pc4", if_id_pc_plus4, 32'h0000_0024);
    exc_req = 1'b1; #1;
    chk("exc_squash", {31'd0, squash_id}, 32'd1);
    step(); exc_req = 1'b0;
    chk("exc_addr",  imem_addr, 32'h0000_0008);
    chk("exc_epc",   epc, 32'h0000_0024);
    chk("exc_epcv",  {31'd0, epc_valid}, 32'd1);
    chk("exc_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    chk("exc_epcv_drop", {31'd0, epc_valid}, 32'd0);
    chk("exc_epc_hold",  epc, 32'h0000_0024);

    // Interrupt held off by stall is taken once the stall clears
    do_jump(32'h0000_0300);
    stall = 1'b1; irq = 1'b1;
    step();
    chk("irqst_addr", imem_addr, 32'h0000_0300);
    chk("irqst_epcv", {31'd0, epc_valid}, 32'd0);
    stall = 1'b0;
    step(); irq = 1'b0;
    chk("irqst_take_addr", imem_addr, 32'h0000_0004);
    chk("irqst_take_epc",  epc, 32'h0000_0304);
    chk("irqst_take_epcv", {31'd0, epc_valid}, 32'd1);

    // Reset during a stall with irq pending
    do_jump(32'h0000_0300);
    stall = 1'b1; irq = 1'b1; reset = 1'b1; #1;
    chk("rst2_squash", {31'd0, squash_id}, 32'd0);
    step();
    chk("rst2_addr",  imem_addr, 32'h0000_0000);
    chk("rst2_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst2_epcv",  {31'd0, epc_valid}, 32'd0);
    chk("rst2_epc",   epc, 32'h0);
    chk("rst2_pc4",   if_id_pc_plus4, 32'h0);
    reset = 1'b0; stall = 1'b0; irq = 1'b0;

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
